// File: rtl/lifo_stack.sv
// Single-clock LIFO stack: push writes at the stack pointer, pop registers the top word onto q_o.
// A simultaneous push and pop returns the old top and overwrites it in place.
module lifo_stack #(
    parameter int unsigned DWIDTH = 8,
    parameter int unsigned AWIDTH = 4
) (
    input  logic              clk_i,
    input  logic              srst_i,
    input  logic              wrreq_i,
    input  logic [DWIDTH-1:0] data_i,
    input  logic              rdreq_i,
    output logic [DWIDTH-1:0] q_o,
    output logic              empty_o,
    output logic              full_o,
    output logic [AWIDTH:0]   usedw_o
);

    localparam int unsigned DEPTH = 2 ** AWIDTH;
    localparam logic [AWIDTH:0]   DepthW = {1'b1, {AWIDTH{1'b0}}};
    localparam logic [AWIDTH:0]   OneW   = {{AWIDTH{1'b0}}, 1'b1};
    localparam logic [AWIDTH-1:0] OneA   = {{(AWIDTH-1){1'b0}}, 1'b1};

    logic [DWIDTH-1:0] mem_q [DEPTH];
    logic [AWIDTH:0]   usedw_q, usedw_d;
    logic [DWIDTH-1:0] q_q, q_d;

    logic              is_empty, is_full;
    logic              pop_ok, mem_we;
    logic [AWIDTH-1:0] top_addr, wr_addr;

    always_comb begin
        is_empty = (usedw_q == '0);
        is_full  = (usedw_q == DepthW);
        // Wraps to DEPTH-1 when the stack is full, which is exactly the top slot.
        top_addr = usedw_q[AWIDTH-1:0] - OneA;
        pop_ok   = rdreq_i && !is_empty;
        mem_we   = wrreq_i && (pop_ok || !is_full);
        wr_addr  = pop_ok ? top_addr : usedw_q[AWIDTH-1:0];

        usedw_d = usedw_q;
        if (mem_we && !pop_ok) begin
            usedw_d = usedw_q + OneW;
        end else if (pop_ok && !wrreq_i) begin
            usedw_d = usedw_q - OneW;
        end

        q_d = q_q;
        if (pop_ok) begin
            q_d = mem_q[top_addr];
        end
    end

    always_ff @(posedge clk_i) begin
        if (srst_i) begin
            usedw_q <= '0;
            q_q     <= '0;
        end else begin
            usedw_q <= usedw_d;
            q_q     <= q_d;
        end
    end

    // Storage is not cleared on reset; reset only blocks the write.
    always_ff @(posedge clk_i) begin
        if (mem_we && !srst_i) begin
            mem_q[wr_addr] <= data_i;
        end
    end

    always_comb begin
        q_o     = q_q;
        usedw_o = usedw_q;
        empty_o = is_empty;
        full_o  = is_full;
    end

endmodule

// File: tb/tb_lifo_stack.sv
// Bench for lifo_stack: stimulus queues expected per-edge results, a monitor checks them.
// Directed phases use hand-computed values; random phases use a queue-based stack model.
module tb_lifo_stack;

    localparam int unsigned DW    = 8;
    localparam int unsigned AW    = 4;
    localparam int unsigned DEPTH = 16;

    logic          clk_i = 1'b0;
    logic          srst_i;
    logic          wrreq_i;
    logic [DW-1:0] data_i;
    logic          rdreq_i;
    logic [DW-1:0] q_o;
    logic          empty_o;
    logic          full_o;
    logic [AW:0]   usedw_o;

    lifo_stack #(.DWIDTH(DW), .AWIDTH(AW)) dut (
        .clk_i   (clk_i),
        .srst_i  (srst_i),
        .wrreq_i (wrreq_i),
        .data_i  (data_i),
        .rdreq_i (rdreq_i),
        .q_o     (q_o),
        .empty_o (empty_o),
        .full_o  (full_o),
        .usedw_o (usedw_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [DW-1:0] q;
        int unsigned   used;
        string         tag;
    } exp_t;

    exp_t          exp_q[$];
    int unsigned   n_cmp = 0;
    int unsigned   n_bad = 0;

    // Reference model: plain queue used as a stack.
    logic [DW-1:0] mdl_stk[$];
    logic [DW-1:0] mdl_q = '0;

    task automatic check(input string name, input int unsigned act, input int unsigned req);
        n_cmp++;
        if (act != req) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Monitor: every edge that has a queued expectation is checked 1 time unit later.
    always begin
        @(posedge clk_i);
        #1;
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            check({e.tag, ".q"},     int'(q_o),     int'(e.q));
            check({e.tag, ".usedw"}, int'(usedw_o), e.used);
            check({e.tag, ".empty"}, int'(empty_o), int'(e.used == 0));
            check({e.tag, ".full"},  int'(full_o),  int'(e.used == DEPTH));
        end
    end

    task automatic drive(input logic rst, input logic wr, input logic rd, input logic [DW-1:0] d);
        logic pop_ok;
        srst_i  = rst;
        wrreq_i = wr;
        rdreq_i = rd;
        data_i  = d;
        if (rst) begin
            mdl_stk.delete();
            mdl_q = '0;
        end else begin
            pop_ok = rd && (mdl_stk.size() > 0);
            if (pop_ok) mdl_q = mdl_stk[$];
            if (pop_ok && wr) begin
                mdl_stk[mdl_stk.size()-1] = d;
            end else if (pop_ok) begin
                void'(mdl_stk.pop_back());
            end else if (wr && mdl_stk.size() < DEPTH) begin
                mdl_stk.push_back(d);
            end
        end
    endtask

    task automatic step_dir(input logic rst, input logic wr, input logic rd, input logic [DW-1:0] d,
                            input logic [DW-1:0] eq, input int unsigned eu, input string tag);
        exp_t e;
        @(negedge clk_i);
        drive(rst, wr, rd, d);
        e.q = eq; e.used = eu; e.tag = tag;
        exp_q.push_back(e);
    endtask

    task automatic step_rand(input int unsigned push_pct, input string tag);
        exp_t        e;
        int unsigned r;
        logic        wr, rd;
        r  = $urandom_range(99);
        wr = (r < push_pct);
        rd = !wr || ($urandom_range(7) == 0);
        // Lean toward draining when full and filling when empty so both boundaries recur.
        if (mdl_stk.size() == DEPTH && $urandom_range(1) == 0) rd = 1'b1;
        if (mdl_stk.size() == 0 && $urandom_range(1) == 0) wr = 1'b1;
        @(negedge clk_i);
        drive(1'b0, wr, rd, DW'($urandom));
        e.q = mdl_q; e.used = mdl_stk.size(); e.tag = tag;
        exp_q.push_back(e);
    endtask

    initial begin
        srst_i  = 1'b1;
        wrreq_i = 1'b0;
        rdreq_i = 1'b0;
        data_i  = '0;

        step_dir(1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 0, "reset");

        for (int i = 0; i < 16; i++) begin
            step_dir(1'b0, 1'b1, 1'b0, DW'(i + 1), 8'h00, i + 1, "fill");
        end
        for (int k = 0; k < 16; k++) begin
            step_dir(1'b0, 1'b0, 1'b1, 8'h00, DW'(16 - k), 15 - k, "drain");
        end

        step_dir(1'b0, 1'b1, 1'b0, 8'hAA, 8'h01, 1, "push_aa");
        step_dir(1'b0, 1'b1, 1'b0, 8'hBB, 8'h01, 2, "push_bb");
        step_dir(1'b0, 1'b1, 1'b1, 8'hCC, 8'hBB, 2, "pushpop_cc");
        step_dir(1'b0, 1'b0, 1'b1, 8'h00, 8'hCC, 1, "pop_cc");
        step_dir(1'b0, 1'b0, 1'b1, 8'h00, 8'hAA, 0, "pop_aa");
        step_dir(1'b0, 1'b0, 1'b1, 8'h00, 8'hAA, 0, "pop_empty");
        step_dir(1'b0, 1'b1, 1'b1, 8'h55, 8'hAA, 1, "pushpop_empty");

        for (int i = 0; i < 15; i++) begin
            step_dir(1'b0, 1'b1, 1'b0, DW'(8'h60 + i), 8'hAA, 2 + i, "refill");
        end
        step_dir(1'b0, 1'b1, 1'b0, 8'hFF, 8'hAA, 16, "push_full");
        step_dir(1'b0, 1'b1, 1'b1, 8'h77, 8'h6E, 16, "pushpop_full");
        step_dir(1'b0, 1'b0, 1'b1, 8'h00, 8'h77, 15, "pop_77");
        step_dir(1'b0, 1'b0, 1'b1, 8'h00, 8'h6D, 14, "pop_6d");

        step_dir(1'b1, 1'b1, 1'b1, 8'h99, 8'h00, 0, "reset_mid");
        step_dir(1'b0, 1'b0, 1'b1, 8'h00, 8'h00, 0, "pop_after_rst");

        for (int i = 0; i < 200; i++) step_rand(70, "rand70");
        for (int i = 0; i < 200; i++) step_rand(50, "rand50");

        @(negedge clk_i);
        wrreq_i = 1'b0;
        rdreq_i = 1'b0;
        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk_i);
        #2;
        if (exp_q.size() != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain_queue: %0d expectations unchecked, expected 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
